// File: rtl/ldm_pkg.sv
// ============================================================================
// Module   : ldm_pkg
// Brief    : Shared state encoding and row-slice helper for the LDM scan path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } ldm_state_e;

    // First bit of a row inside a flattened bitmap (row r = [r*cols +: cols]).
    function automatic int row_base(input int row, input int cols);
        return row * cols;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ldm_frame_buf.sv
// ============================================================================
// Module   : ldm_frame_buf
// Brief    : Front/back bitmap buffers with pending flag and frame-boundary swap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldm_frame_buf
    import ldm_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:ROWS*COLS-1]   wr_data,
    input  logic                   wr_en,
    input  logic                   swap_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [0:COLS-1]        rd_data,
    output logic                   pending
);

    logic [0:ROWS*COLS-1] buf0_q, buf0_d;
    logic [0:ROWS*COLS-1] buf1_q, buf1_d;
    logic                 front_sel_q, front_sel_d;
    logic                 pending_q, pending_d;
    logic                 w_swap;
    logic [0:ROWS*COLS-1] w_front_nxt;

    // Read-out and write target both follow the post-edge front selection, so a
    // swapping edge shows the old back contents and a same-edge strobe lands in
    // the buffer that has just become back.
    always_comb begin
        w_swap      = swap_req & pending_q;
        front_sel_d = front_sel_q ^ w_swap;
        pending_d   = wr_en | (pending_q & ~w_swap);
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        if (wr_en) begin
            if (front_sel_d) buf0_d = wr_data;
            else             buf1_d = wr_data;
        end
        w_front_nxt = front_sel_d ? buf1_q : buf0_q;
        rd_data     = w_front_nxt[row_base(32'(rd_addr), COLS) +: COLS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/ldm_scan_ctrl.sv
// ============================================================================
// Module   : ldm_scan_ctrl
// Brief    : Row-scan controller for the LED dot-matrix; tear-free frame swap.
//            Optional macro LDM_SCAN_BLANK_EN adds a blanking gap after each row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldm_scan_ctrl
    import ldm_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int ADDR_W    = $clog2(ROWS),
    parameter int DWELL     = 64,
    parameter int BLANK_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:ROWS*COLS-1] PIXEL_DATA,
    input  logic                 PIXEL_DATA_EN,
    output logic                 LDM_CLK,
    output logic                 LDM_ADDR_EN,
    output logic [ADDR_W-1:0]    LDM_ADDR,
    output logic [0:COLS-1]      LDM_LINE_DATA,
    output logic                 FRAME_START
);

    localparam int c_DW_W  = $clog2(DWELL);
    localparam int c_BL_W  = $clog2(BLANK_CYC + 1);
    localparam int c_CNT_W = (c_DW_W > c_BL_W) ? c_DW_W : c_BL_W;

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_HALF       = c_CNT_W'(DWELL / 2);
    localparam logic [ADDR_W-1:0]  c_ROW_LAST   = ADDR_W'(ROWS - 1);
`ifdef LDM_SCAN_BLANK_EN
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);
`endif

    ldm_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 ldm_clk_q, ldm_clk_d;
    logic                 addr_en_q, addr_en_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [0:COLS-1]      line_q, line_d;
    logic                 frame_start_q, frame_start_d;

    logic [ADDR_W-1:0]    w_row_nxt;
    logic                 w_swap_req;
    logic                 w_pending;
    logic [0:COLS-1]      w_rd_data;

    ldm_frame_buf #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_frame_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (PIXEL_DATA),
        .wr_en    (PIXEL_DATA_EN),
        .swap_req (w_swap_req),
        .rd_addr  (row_d),
        .rd_data  (w_rd_data),
        .pending  (w_pending)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        w_swap_req = 1'b0;
        w_row_nxt  = (row_q == c_ROW_LAST) ? '0 : row_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (w_pending) begin
                    state_d    = ST_SHOW;
                    row_d      = '0;
                    cnt_d      = '0;
                    w_swap_req = 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == c_DWELL_LAST) begin
                    cnt_d = '0;
`ifdef LDM_SCAN_BLANK_EN
                    state_d = ST_BLANK;
`else
                    row_d      = w_row_nxt;
                    w_swap_req = (w_row_nxt == '0);
`endif
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
`ifdef LDM_SCAN_BLANK_EN
            ST_BLANK: begin
                if (cnt_q == c_BLANK_LAST) begin
                    state_d    = ST_SHOW;
                    cnt_d      = '0;
                    row_d      = w_row_nxt;
                    w_swap_req = (w_row_nxt == '0);
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with it.
        ldm_clk_d     = 1'b0;
        addr_en_d     = 1'b0;
        addr_d        = '0;
        line_d        = '0;
        frame_start_d = 1'b0;
        if (state_d == ST_SHOW) begin
            ldm_clk_d     = (cnt_d >= c_HALF);
            addr_en_d     = 1'b1;
            addr_d        = row_d;
            line_d        = w_rd_data;
            frame_start_d = (row_d == '0) && (cnt_d == '0);
        end else if (state_d == ST_BLANK) begin
            addr_d = row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            cnt_q         <= '0;
            ldm_clk_q     <= 1'b0;
            addr_en_q     <= 1'b0;
            addr_q        <= '0;
            line_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            ldm_clk_q     <= ldm_clk_d;
            addr_en_q     <= addr_en_d;
            addr_q        <= addr_d;
            line_q        <= line_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign LDM_CLK       = ldm_clk_q;
    assign LDM_ADDR_EN   = addr_en_q;
    assign LDM_ADDR      = addr_q;
    assign LDM_LINE_DATA = line_q;
    assign FRAME_START   = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_ldm_scan_ctrl.sv
// ============================================================================
// Module   : tb_ldm_scan_ctrl
// Brief    : Directed self-checking bench for ldm_scan_ctrl (16x16, short dwell).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldm_scan_ctrl;

    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int ADDR_W    = 4;
    localparam int DWELL     = 8;
    localparam int BLANK_CYC = 4;
`ifdef LDM_SCAN_BLANK_EN
    localparam int ROW_P     = DWELL + BLANK_CYC;
`else
    localparam int ROW_P     = DWELL;
`endif
    localparam int FRAME     = ROWS * ROW_P;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [0:ROWS*COLS-1] pixel_data = '0;
    logic                 pixel_en = 1'b0;
    logic                 ldm_clk;
    logic                 ldm_addr_en;
    logic [ADDR_W-1:0]    ldm_addr;
    logic [0:COLS-1]      ldm_line;
    logic                 frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;   // cycles since row 0 of the first displayed frame began
    int fb       = 0;   // pos at which the current frame began

    ldm_scan_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .ADDR_W    (ADDR_W),
        .DWELL     (DWELL),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PIXEL_DATA    (pixel_data),
        .PIXEL_DATA_EN (pixel_en),
        .LDM_CLK       (ldm_clk),
        .LDM_ADDR_EN   (ldm_addr_en),
        .LDM_ADDR      (ldm_addr),
        .LDM_LINE_DATA (ldm_line),
        .FRAME_START   (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ramp_row(input int r);
        return 16'hffff >> r;
    endfunction

    function automatic logic [0:ROWS*COLS-1] ramp_img();
        logic [0:ROWS*COLS-1] img;
        for (int r = 0; r < ROWS; r++) img[r*COLS +: COLS] = ramp_row(r);
        return img;
    endfunction

    function automatic logic [0:ROWS*COLS-1] fill_img(input logic [15:0] v);
        logic [0:ROWS*COLS-1] img;
        for (int r = 0; r < ROWS; r++) img[r*COLS +: COLS] = v;
        return img;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pos++;
        end
    endtask

    task automatic step_to(input int target);
        step(target - pos);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (ldm_clk !== 1'b0)     begin n_fail++; $display("FAIL rst_ldm_clk: got %b want 0", ldm_clk); end
        n_checks++; if (ldm_addr_en !== 1'b0) begin n_fail++; $display("FAIL rst_addr_en: got %b want 0", ldm_addr_en); end
        n_checks++; if (ldm_addr !== 4'd0)    begin n_fail++; $display("FAIL rst_addr: got %0d want 0", ldm_addr); end
        n_checks++; if (ldm_line !== 16'h0)   begin n_fail++; $display("FAIL rst_line: got %h want 0000", ldm_line); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        rst = 1'b0;
        tick(); tick();
        n_checks++; if (ldm_addr_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_strobe: addr_en got %b want 0", ldm_addr_en); end
    endtask

    task automatic test_first_frame();
        pixel_data = ramp_img();
        pixel_en   = 1'b1;
        tick();
        pixel_en   = 1'b0;
        tick();
        pos = 0;
        fb  = 0;
        n_checks++; if (ldm_addr !== 4'd0)     begin n_fail++; $display("FAIL first_addr: got %0d want 0", ldm_addr); end
        n_checks++; if (ldm_line !== 16'hffff) begin n_fail++; $display("FAIL first_line: got %h want ffff", ldm_line); end
        n_checks++; if (ldm_addr_en !== 1'b1)  begin n_fail++; $display("FAIL first_addr_en: got %b want 1", ldm_addr_en); end
        n_checks++; if (frame_start !== 1'b1)  begin n_fail++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
        n_checks++; if (ldm_clk !== 1'b0)      begin n_fail++; $display("FAIL first_ldm_clk: got %b want 0", ldm_clk); end
        step(1);
        n_checks++; if (frame_start !== 1'b0)  begin n_fail++; $display("FAIL frame_start_one_cycle: got %b want 0", frame_start); end
        step_to(DWELL/2 - 1);
        n_checks++; if (ldm_clk !== 1'b0)      begin n_fail++; $display("FAIL ldm_clk_low_half: got %b want 0", ldm_clk); end
        step(1);
        n_checks++; if (ldm_clk !== 1'b1)      begin n_fail++; $display("FAIL ldm_clk_high_half: got %b want 1", ldm_clk); end
        step_to(ROW_P);
        n_checks++; if (ldm_addr !== 4'd1)     begin n_fail++; $display("FAIL row1_addr: got %0d want 1", ldm_addr); end
        n_checks++; if (ldm_line !== 16'h7fff) begin n_fail++; $display("FAIL row1_line: got %h want 7fff", ldm_line); end
        n_checks++; if (ldm_clk !== 1'b0)      begin n_fail++; $display("FAIL row1_ldm_clk: got %b want 0", ldm_clk); end
    endtask

    task automatic test_full_frame();
        for (int r = 2; r < ROWS; r++) begin
            step_to(fb + r*ROW_P);
            n_checks++;
            if (ldm_addr !== 4'(r) || ldm_line !== ramp_row(r)) begin
                n_fail++;
                $display("FAIL ramp_row%0d: got addr %0d line %h want addr %0d line %h", r, ldm_addr, ldm_line, r, ramp_row(r));
            end
        end
        step_to(fb + FRAME - 1);
        n_checks++; if (frame_start !== 1'b0)  begin n_fail++; $display("FAIL last_row_frame_start: got %b want 0", frame_start); end
        step(1);
        fb = pos;
        n_checks++; if (ldm_addr !== 4'd0)     begin n_fail++; $display("FAIL wrap_addr: got %0d want 0", ldm_addr); end
        n_checks++; if (ldm_line !== 16'hffff) begin n_fail++; $display("FAIL repeat_line: got %h want ffff", ldm_line); end
        n_checks++; if (frame_start !== 1'b1)  begin n_fail++; $display("FAIL repeat_frame_start: got %b want 1", frame_start); end
    endtask

    task automatic test_mid_frame_strobe();
        step_to(fb + ROW_P + 2);
        pixel_data = fill_img(16'h5555);
        pixel_en   = 1'b1;
        step(1);
        pixel_en   = 1'b0;
        n_checks++; if (ldm_line !== 16'h7fff) begin n_fail++; $display("FAIL strobe_no_tear: got %h want 7fff", ldm_line); end
        for (int r = 2; r < ROWS; r++) begin
            step_to(fb + r*ROW_P + 1);
            n_checks++;
            if (ldm_line !== ramp_row(r)) begin
                n_fail++;
                $display("FAIL keep_ramp_row%0d: got %h want %h", r, ldm_line, ramp_row(r));
            end
        end
        step_to(fb + FRAME);
        fb = pos;
        n_checks++; if (ldm_line !== 16'h5555) begin n_fail++; $display("FAIL new_frame_line: got %h want 5555", ldm_line); end
        n_checks++; if (frame_start !== 1'b1)  begin n_fail++; $display("FAIL new_frame_start: got %b want 1", frame_start); end
        step_to(fb + 5*ROW_P);
        n_checks++; if (ldm_addr !== 4'd5 || ldm_line !== 16'h5555) begin n_fail++; $display("FAIL new_frame_row5: got addr %0d line %h want addr 5 line 5555", ldm_addr, ldm_line); end
    endtask

    task automatic test_swap_edge_strobe();
        step_to(fb + 3*ROW_P);
        pixel_data = fill_img(16'h3c3c);
        pixel_en   = 1'b1;
        step(1);
        pixel_en   = 1'b0;
        step_to(fb + FRAME - 1);
        n_checks++; if (ldm_line !== 16'h5555) begin n_fail++; $display("FAIL pre_swap_line: got %h want 5555", ldm_line); end
        pixel_data = fill_img(16'hc3c3);
        pixel_en   = 1'b1;
        step(1);
        pixel_en   = 1'b0;
        fb = pos;
        n_checks++; if (ldm_line !== 16'h3c3c) begin n_fail++; $display("FAIL swap_edge_old_back: got %h want 3c3c", ldm_line); end
        n_checks++; if (frame_start !== 1'b1)  begin n_fail++; $display("FAIL swap_edge_frame_start: got %b want 1", frame_start); end
        step_to(fb + 4*ROW_P + 1);
        n_checks++; if (ldm_line !== 16'h3c3c) begin n_fail++; $display("FAIL swap_edge_row4: got %h want 3c3c", ldm_line); end
        step_to(fb + FRAME);
        fb = pos;
        n_checks++; if (ldm_line !== 16'hc3c3) begin n_fail++; $display("FAIL pending_kept_line: got %h want c3c3", ldm_line); end
        step_to(fb + FRAME);
        fb = pos;
        n_checks++; if (ldm_line !== 16'hc3c3 || frame_start !== 1'b1) begin n_fail++; $display("FAIL repeat_after_swap: got line %h fs %b want c3c3 1", ldm_line, frame_start); end
    endtask

    task automatic test_back_to_back();
        step_to(fb + 2*ROW_P + DWELL - 1);
        n_checks++; if (ldm_addr !== 4'd2 || ldm_clk !== 1'b1) begin n_fail++; $display("FAIL row_end: got addr %0d clk %b want 2 1", ldm_addr, ldm_clk); end
`ifdef LDM_SCAN_BLANK_EN
        for (int b = 0; b < BLANK_CYC; b++) begin
            step(1);
            n_checks++;
            if (ldm_addr_en !== 1'b0 || ldm_line !== 16'h0 || ldm_clk !== 1'b0 || ldm_addr !== 4'd2) begin
                n_fail++;
                $display("FAIL blank_cyc%0d: got en %b line %h clk %b addr %0d want 0 0000 0 2", b, ldm_addr_en, ldm_line, ldm_clk, ldm_addr);
            end
        end
`endif
        step(1);
        n_checks++;
        if (ldm_addr !== 4'd3 || ldm_addr_en !== 1'b1 || ldm_line !== 16'hc3c3 || ldm_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL next_row_start: got addr %0d en %b line %h clk %b want 3 1 c3c3 0", ldm_addr, ldm_addr_en, ldm_line, ldm_clk);
        end
    endtask

    task automatic test_reset_mid_row();
        bit seen_active;
        step_to(fb + 7*ROW_P + 3);
        n_checks++; if (ldm_addr !== 4'd7) begin n_fail++; $display("FAIL pre_reset_addr: got %0d want 7", ldm_addr); end
        pixel_data = fill_img(16'haaaa);
        pixel_en   = 1'b1;
        tick();
        pixel_en   = 1'b0;
        rst        = 1'b1;
        tick();
        n_checks++; if (ldm_clk !== 1'b0)     begin n_fail++; $display("FAIL midrst_ldm_clk: got %b want 0", ldm_clk); end
        n_checks++; if (ldm_addr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_addr_en: got %b want 0", ldm_addr_en); end
        n_checks++; if (ldm_addr !== 4'd0)    begin n_fail++; $display("FAIL midrst_addr: got %0d want 0", ldm_addr); end
        n_checks++; if (ldm_line !== 16'h0)   begin n_fail++; $display("FAIL midrst_line: got %h want 0000", ldm_line); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_start: got %b want 0", frame_start); end
        rst = 1'b0;
        seen_active = 1'b0;
        for (int i = 0; i < 3*ROW_P; i++) begin
            tick();
            if (ldm_addr_en !== 1'b0 || frame_start !== 1'b0) seen_active = 1'b1;
        end
        n_checks++; if (seen_active !== 1'b0) begin n_fail++; $display("FAIL stay_idle: got active %b want 0", seen_active); end
        pixel_data = fill_img(16'h0f0f);
        pixel_en   = 1'b1;
        tick();
        pixel_en   = 1'b0;
        tick();
        n_checks++;
        if (ldm_addr_en !== 1'b1 || ldm_addr !== 4'd0 || ldm_line !== 16'h0f0f || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got en %b addr %0d line %h fs %b want 1 0 0f0f 1", ldm_addr_en, ldm_addr, ldm_line, frame_start);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_full_frame();
        test_mid_frame_strobe();
        test_swap_edge_strobe();
        test_back_to_back();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
